// File: rtl/serial_op_unit.sv
// serial_op_unit: bit-serial evaluator for the shift (<<, >>, >>>) and
// reduction (&, |, ^) operators. One bit-step per clock under a
// start/busy/done handshake; the result is held until the next completion.
module serial_op_unit #(
    parameter int W  = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [W-1:0]  a,
    input  logic [AW-1:0] amt,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [2:0] OP_SLL  = 3'd0;
    localparam logic [2:0] OP_SRL  = 3'd1;
    localparam logic [2:0] OP_SRA  = 3'd2;
    localparam logic [2:0] OP_RAND = 3'd3;
    localparam logic [2:0] OP_ROR  = 3'd4;
    localparam logic [2:0] OP_RXOR = 3'd5;

    // W always fits in the amount width, so the step counter shares it.
    localparam logic [AW-1:0] W_AMT = AW'(W);
    localparam logic [AW-1:0] ONE   = {{(AW-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [W-1:0]    work_q, work_d;
    logic            acc_q, acc_d;
    logic            msb_q, msb_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    result_q, result_d;

    logic [W-1:0]    work_step;
    logic            acc_step;
    logic [AW-1:0]   n_start;
    logic            op_is_shift;
    logic            op_q_is_red;

    assign op_is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    assign op_q_is_red = (op_q == OP_RAND) || (op_q == OP_ROR) || (op_q == OP_RXOR);

    // Step count for a fresh request: clamped shift amount, full width for
    // reductions, zero for illegal opcodes (they finish straight away).
    always_comb begin
        n_start = '0;
        case (op)
            OP_SLL, OP_SRL, OP_SRA:  n_start = (amt >= W_AMT) ? W_AMT : amt;
            OP_RAND, OP_ROR, OP_RXOR: n_start = W_AMT;
            default:                 n_start = '0;
        endcase
    end

    // One serial step of the captured operation on the working register.
    always_comb begin
        work_step = work_q;
        acc_step  = acc_q;
        case (op_q)
            OP_SLL:  work_step = work_q << 1;
            OP_SRL:  work_step = work_q >> 1;
            OP_SRA:  work_step = {msb_q, work_q[W-1:1]};
            OP_RAND: begin
                acc_step  = acc_q & work_q[0];
                work_step = work_q >> 1;
            end
            OP_ROR: begin
                acc_step  = acc_q | work_q[0];
                work_step = work_q >> 1;
            end
            OP_RXOR: begin
                acc_step  = acc_q ^ work_q[0];
                work_step = work_q >> 1;
            end
            default: ;
        endcase
    end

    // Next-state and datapath control for IDLE -> RUN -> DONE.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        acc_d    = acc_q;
        msb_d    = msb_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    work_d = a;
                    msb_d  = a[W-1];
                    acc_d  = (op == OP_RAND);
                    cnt_d  = n_start;
                    if (n_start != '0) begin
                        state_d = S_RUN;
                    end else begin
                        // Zero-length: shift by 0 passes a through, illegal gives 0.
                        state_d  = S_DONE;
                        result_d = op_is_shift ? a : '0;
                    end
                end
            end
            S_RUN: begin
                work_d = work_step;
                acc_d  = acc_step;
                cnt_d  = cnt_q - ONE;
                if (cnt_q == ONE) begin
                    state_d  = S_DONE;
                    result_d = op_q_is_red ? {{(W-1){1'b0}}, acc_step} : work_step;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            work_q   <= '0;
            acc_q    <= 1'b0;
            msb_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            acc_q    <= acc_d;
            msb_q    <= msb_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: doc/serial_op_unit.md
# serial_op_unit

Multi-cycle, bit-serial evaluator for the Verilog shift and reduction operators. It accepts one operand word plus an opcode and computes the result one bit-step per clock, under a start/done handshake. It sits in the operator regression suite as the sequential counterpart of the combinational operators: every result it produces must equal the corresponding single-expression Verilog operator, and benches check this equality by assertion. Values are two-state only.

## Interface

Parameters:
- `W`, default 32: operand and result width; must be ≥ 2.
- `AW`, default 6: width of `amt`; must satisfy 2^AW > W.

Ports (clock and reset first):
- `clk` — input, 1 bit: single clock; all state updates on its rising edge.
- `rst` — input, 1 bit: asynchronous, active-high reset.
- `start` — input, 1 bit: request; sampled only when `busy`=0.
- `op` — input, 3 bits: opcode. 0 = SLL (`<<`), 1 = SRL (`>>`), 2 = SRA (`>>>`, signed), 3 = RAND (`&`), 4 = ROR (`|`), 5 = RXOR (`^`), 6–7 = illegal.
- `a` — input, W bits: operand.
- `amt` — input, AW bits: shift amount, unsigned; ignored for reductions.
- `busy` — output, 1 bit: high while a request is in flight, i.e. the state is not IDLE.
- `done` — output, 1 bit: single-cycle pulse; `result` is valid.
- `result` — output, W bits: last completed result, held until the next completion.

## Operation

- **States:** IDLE, RUN, DONE.
- **IDLE → accept:** `start`=1 captures `op`, `a` and `amt`. The block then computes the step count N:
  - Shifts: N = min(`amt`, W).
  - Reductions: N = W.
  - Illegal opcodes: N = 0.
- **Transition out of IDLE:** go to RUN if N > 0, otherwise go to DONE.
- **RUN:** performs one step per edge and decrements the counter. When the last step completes, go to DONE.
  - SLL: working register shifts left by 1, zero fill.
  - SRL: shifts right by 1, zero fill.
  - SRA: shifts right by 1, filling with the captured MSB.
  - Reductions: accumulator combines working-register bit 0, then the register shifts right by 1 (LSB first). Accumulator initial values: RAND = 1, ROR = 0, RXOR = 0.
- **DONE:** lasts exactly one cycle with `done`=1, then returns to IDLE.
  - `result` is loaded on the edge that enters DONE.
  - Shift results are the working register.
  - Reduction results are {W-1 zeros, acc}.
  - Illegal opcodes give all zeros.
  - N = 0 for a shift gives `result` = `a` unchanged.
- **Shift amounts ≥ W** are clamped to W: SLL and SRL give 0; SRA gives all copies of the sign bit.
- **`start` while `busy`=1** (RUN or DONE) is ignored. There is no queueing, and the captured operands are unaffected.
- **Input changes:** `a`, `op` and `amt` may change freely after acceptance without affecting the request in flight.

## Timing

- **Reset values:** `busy`=0, `done`=0, `result`=0, state IDLE, internal counter/working register/accumulator = 0.
- **Acceptance edge:** call it k0, the edge where IDLE samples `start`=1. From k0 on, `busy` reads 1.
- **Completion:** `done`=1 and the new `result` are visible in the cycle after edge k0+N. `done` falls, and `busy` falls, after edge k0+N+1.
- **Throughput:** the earliest next acceptance is edge k0+N+2. Requests are spaced by N+2 cycles.
- **Reset mid-operation:** `rst` asserted in any state returns the block to IDLE immediately (asynchronous).
  - No `done` pulse is produced for the aborted request.
  - `result` is cleared to 0.
- **Reset release:** the first edge after `rst` deasserts may accept `start`.
- **`done` vs `start`:** `done` never coincides with acceptance of a new `start`.

## Test plan

1. **Small shifts and the zero-shift case**
   - SLL, `a`=32'h9, `amt`=1 → `result`=32'h12; `done` after edge k0+1; `busy` high for 2 cycles.
   - SRL, `a`=32'h9, `amt`=1 → `result`=32'h4.
   - `amt`=0 → `result`=32'h9 after edge k0.
2. **Arithmetic shift and clamping**
   - SRA, `a`=32'hFFFFFFFE, `amt`=1 → 32'hFFFFFFFF.
   - SRA, `a`=32'h1, `amt`=1 → 0.
   - SRA, `a`=32'h80000000, `amt`=40 → 32'hFFFFFFFF with N=32.
   - SLL, `a`=1, `amt`=6 → 64.
3. **Reductions** — each has `done` after edge k0+32.
   - `a`=32'h9: RAND → 0, ROR → 1, RXOR → 0.
   - `a`=32'hFFFFFFFF: RAND → 1.
   - `a`=32'h7: RXOR → 1.
4. **Illegal opcode** — `op`=6 with `a`=32'hFFFF → `result`=0 and `done` after edge k0.
5. **Handshake robustness**
   - Start SLL, `amt`=5, then hold `start`=1 with different `op`/`a` through RUN and DONE.
   - Required: exactly one `done` carrying the first request's result; the second request is accepted only at edge k0+7.
   - Every result in scenarios 1–4 must equal the matching combinational operator applied to the same inputs.
6. **Reset mid-operation**
   - Start RXOR; assert `rst` at edge k0+10.
   - Required: `busy`=0, `done`=0, `result`=0 immediately.
   - After release, SLL, `a`=3, `amt`=2 → 32'hC with normal timing.
